gpx2_lvds_tx: RTL and testbench

//  Transmit side of the GPX2 LVDS result interface: serializes one result packet (start + 4 stop words)

---
 rtl/gpx2_lvds_tx_pkg.sv | 33 +++
 rtl/gpx2_lvds_tx_if.sv | 34 +++
 rtl/gpx2_lvds_clkgen.sv | 49 ++++
 rtl/gpx2_lvds_tx.sv | 164 ++++++++++++++++
 tb/tb_gpx2_lvds_tx.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpx2_lvds_tx_pkg.sv
`default_nettype none
// ============================================================================
// | Module   : gpx2_lvds_tx_pkg                                              |
// | Purpose  : Shared GPX2 constants, state encoding and result-word helper  |
// |            for the LVDS transmit (emulator) path.                        |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// ============================================================================
package gpx2_lvds_tx_pkg;

   localparam int          GPX2_WORD_W    = 32;
   localparam int          GPX2_NUM_WORDS = 5;
   localparam logic [31:0] GPX2_NO_HIT    = 32'hFFFF_FFFF;
   localparam int          GPX2_REFCLK_PS = 40000;

   typedef logic [GPX2_WORD_W-1:0] gpx2_word_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_GAP    = 3'd3,
      ST_FINISH = 3'd4
   } gpx2_tx_state_t;

   // Stop-minus-start time in ps from two result words {8'h00, refidx, tstop}.
   function automatic int gpx2_rise_ps(input gpx2_word_t start_w, input gpx2_word_t stop_w);
      return (int'(stop_w[23:16]) - int'(start_w[23:16])) * GPX2_REFCLK_PS
           + int'(stop_w[15:0]) - int'(start_w[15:0]);
   endfunction

endpackage
`default_nettype wire

// File: rtl/gpx2_lvds_tx_if.sv
`default_nettype none
// ============================================================================
// | Module   : gpx2_lvds_tx_if                                               |
// | Purpose  : Packet request handshake between sequencer and LVDS tx.       |
// | Signals  : i_tx_valid / o_tx_ready handshake, five result words,         |
// |            o_tx_busy / o_tx_done status.                                 |
// |            master = sequencer side, slave = gpx2_lvds_tx side.           |
// | Revision : 1.0  initial release                                          |
// ============================================================================
interface gpx2_lvds_tx_if;
   import gpx2_lvds_tx_pkg::*;

   logic       i_tx_valid;
   logic       o_tx_ready;
   gpx2_word_t i_start;
   gpx2_word_t i_sto11;
   gpx2_word_t i_sto12;
   gpx2_word_t i_sto21;
   gpx2_word_t i_sto22;
   logic       o_tx_busy;
   logic       o_tx_done;

   modport master (
      output i_tx_valid, i_start, i_sto11, i_sto12, i_sto21, i_sto22,
      input  o_tx_ready, o_tx_busy, o_tx_done
   );

   modport slave (
      input  i_tx_valid, i_start, i_sto11, i_sto12, i_sto21, i_sto22,
      output o_tx_ready, o_tx_busy, o_tx_done
   );

endinterface
`default_nettype wire

// File: rtl/gpx2_lvds_clkgen.sv
`default_nettype none
// ============================================================================
// | Module   : gpx2_lvds_clkgen                                              |
// | Purpose  : Free-running LVDS serial clock divider with edge strobes.     |
// | Ports    : i_clk, i_rst_n (async, active-low)                            |
// |            o_lvds_clk  - registered serial clock, period 2*CLK_DIV       |
// |            o_fall_stb  - high in the i_clk cycle o_lvds_clk goes 1->0    |
// |            o_rise_stb  - high in the i_clk cycle o_lvds_clk goes 0->1    |
// | Revision : 1.0  initial release                                          |
// ============================================================================
module gpx2_lvds_clkgen #(
   parameter int CLK_DIV = 4
) (
   input  wire  i_clk,
   input  wire  i_rst_n,
   output logic o_lvds_clk,
   output logic o_fall_stb,
   output logic o_rise_stb
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] c_term = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_lvds_clk;
   logic          w_tc;

   assign w_tc = (r_cnt == c_term);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_lvds_clk <= 1'b0;
      end else if (w_tc) begin
         r_cnt      <= '0;
         r_lvds_clk <= ~r_lvds_clk;
      end else begin
         r_cnt      <= r_cnt + 1'b1;
      end
   end

   // Strobes are decoded from the current flop state, so they coincide with
   // the i_clk edge that launches the new o_lvds_clk level.
   assign o_lvds_clk = r_lvds_clk;
   assign o_fall_stb = w_tc &  r_lvds_clk;
   assign o_rise_stb = w_tc & ~r_lvds_clk;

endmodule
`default_nettype wire

// File: rtl/gpx2_lvds_tx.sv
`default_nettype none
// ============================================================================
// | Module   : gpx2_lvds_tx                                                  |
// | Purpose  : GPX2 LVDS result transmitter (emulator): serializes start +   |
// |            4 stop words MSB first with frame, GAP_BITS periods between.  |
// | Ports    : i_clk, i_rst_n (async, active-low)                            |
// |            tx_if        - slave side of packet handshake interface       |
// |            o_lvds_clk   - free-running serial clock                      |
// |            o_lvds_frame - high during the WORD_W bits of each word       |
// |            o_lvds_sdo   - serial data, changes on lvds_clk falling edge  |
// | Revision : 1.0  initial release                                          |
// ============================================================================
module gpx2_lvds_tx
   import gpx2_lvds_tx_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int WORD_W    = GPX2_WORD_W,
   parameter int NUM_WORDS = GPX2_NUM_WORDS,
   parameter int GAP_BITS  = 2
) (
   input  wire            i_clk,
   input  wire            i_rst_n,
   gpx2_lvds_tx_if.slave  tx_if,
   output logic           o_lvds_clk,
   output logic           o_lvds_frame,
   output logic           o_lvds_sdo
);

   localparam int BW = $clog2(WORD_W);
   localparam int GW = $clog2(GAP_BITS + 1);
   // After the MSB is launched, WORD_W-1 bits remain, counted down to 0.
   localparam logic [BW-1:0] c_bit_init  = BW'(WORD_W - 2);
   localparam logic [GW-1:0] c_gap_init  = GW'(GAP_BITS - 1);
   localparam logic [2:0]    c_last_word = 3'(NUM_WORDS - 1);

   gpx2_tx_state_t     r_state;
   logic [WORD_W-1:0]  r_shadow [NUM_WORDS];
   logic [WORD_W-1:0]  r_shift;
   logic [BW-1:0]      r_bit_cnt;
   logic               r_last;
   logic [2:0]         r_word_cnt;
   logic [GW-1:0]      r_gap_cnt;
   logic               r_frame;
   logic               r_sdo;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;

   logic               w_fall_stb;
   logic               w_unused_rise_stb;
   logic [2:0]         w_load_idx;
   logic [WORD_W-1:0]  w_load_word;

   gpx2_lvds_clkgen #(
      .CLK_DIV (CLK_DIV)
   ) u_clkgen (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .o_lvds_clk (o_lvds_clk),
      .o_fall_stb (w_fall_stb),
      .o_rise_stb (w_unused_rise_stb)
   );

   // ARM always starts with the start word; GAP moves on to the next one.
   assign w_load_idx  = (r_state == ST_ARM) ? 3'd0 : (r_word_cnt + 3'd1);
   assign w_load_word = r_shadow[w_load_idx];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         for (int i = 0; i < NUM_WORDS; i++) r_shadow[i] <= '0;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_last     <= 1'b0;
         r_word_cnt <= '0;
         r_gap_cnt  <= '0;
         r_frame    <= 1'b0;
         r_sdo      <= 1'b0;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (tx_if.i_tx_valid && r_ready) begin
                  r_shadow[0] <= tx_if.i_start;
                  r_shadow[1] <= tx_if.i_sto11;
                  r_shadow[2] <= tx_if.i_sto12;
                  r_shadow[3] <= tx_if.i_sto21;
                  r_shadow[4] <= tx_if.i_sto22;
                  r_word_cnt  <= '0;
                  r_ready     <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_ARM;
               end
            end
            ST_ARM: begin
               if (w_fall_stb) begin
                  r_frame   <= 1'b1;
                  r_sdo     <= w_load_word[WORD_W-1];
                  r_shift   <= {w_load_word[WORD_W-2:0], 1'b0};
                  r_bit_cnt <= c_bit_init;
                  r_last    <= 1'b0;
                  r_state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (w_fall_stb) begin
                  if (r_last) begin
                     // Bit 0 has been held for a full period: close the word.
                     r_frame <= 1'b0;
                     r_sdo   <= 1'b0;
                     if (r_word_cnt == c_last_word) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_FINISH;
                     end else begin
                        r_gap_cnt <= c_gap_init;
                        r_state   <= ST_GAP;
                     end
                  end else begin
                     r_sdo   <= r_shift[WORD_W-1];
                     r_shift <= {r_shift[WORD_W-2:0], 1'b0};
                     // Flag instead of underflowing the bit counter past 0.
                     if (r_bit_cnt == '0) r_last <= 1'b1;
                     else                 r_bit_cnt <= r_bit_cnt - 1'b1;
                  end
               end
            end
            ST_GAP: begin
               if (w_fall_stb) begin
                  if (r_gap_cnt == '0) begin
                     r_word_cnt <= r_word_cnt + 3'd1;
                     r_frame    <= 1'b1;
                     r_sdo      <= w_load_word[WORD_W-1];
                     r_shift    <= {w_load_word[WORD_W-2:0], 1'b0};
                     r_bit_cnt  <= c_bit_init;
                     r_last     <= 1'b0;
                     r_state    <= ST_SHIFT;
                  end else begin
                     r_gap_cnt  <= r_gap_cnt - 1'b1;
                  end
               end
            end
            ST_FINISH: begin
               r_done  <= 1'b0;
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_lvds_frame     = r_frame;
   assign o_lvds_sdo       = r_sdo;
   assign tx_if.o_tx_ready = r_ready;
   assign tx_if.o_tx_busy  = r_busy;
   assign tx_if.o_tx_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_gpx2_lvds_tx.sv
`default_nettype none
// ============================================================================
// | Module   : tb_gpx2_lvds_tx                                               |
// | Purpose  : Directed self-checking bench for gpx2_lvds_tx with an LVDS    |
// |            receiver model and edge-timing monitor.                       |
// | Revision : 1.0  initial release                                          |
// ============================================================================
module tb_gpx2_lvds_tx;
   import gpx2_lvds_tx_pkg::*;

   localparam int CLK_DIV = 4;
   localparam int PERIOD  = 2 * CLK_DIV;

   typedef logic [31:0] pkt_t [5];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic lvds_clk, lvds_frame, lvds_sdo;

   gpx2_lvds_tx_if tx_if ();

   gpx2_lvds_tx #(
      .CLK_DIV   (CLK_DIV),
      .WORD_W    (32),
      .NUM_WORDS (5),
      .GAP_BITS  (2)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .tx_if        (tx_if),
      .o_lvds_clk   (lvds_clk),
      .o_lvds_frame (lvds_frame),
      .o_lvds_sdo   (lvds_sdo)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- receiver model / timing monitor ----------------
   logic [31:0] rx_words [$];
   int          rx_bits  [$];
   int          rx_gaps  [$];
   logic [31:0] rx_shreg    = '0;
   int          rx_bitcnt   = 0;
   int          low_cnt     = 0;
   bit          gap_pending = 1'b0;
   int          viol_cnt    = 0;
   int          bad_period  = 0;
   int          done_cnt    = 0;
   int          done_long   = 0;
   int          cyc         = 0;
   int          last_rise   = 0;
   bit          have_rise   = 1'b0;
   logic        p_clk = 1'b0, p_frame = 1'b0, p_sdo = 1'b0, p_done = 1'b0, p_rst = 1'b0;

   initial forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         rx_bitcnt   = 0;
         rx_shreg    = '0;
         low_cnt     = 0;
         gap_pending = 1'b0;
         have_rise   = 1'b0;
      end else begin
         // frame/sdo may only move in the cycle lvds_clk falls
         if (p_rst && (lvds_frame !== p_frame || lvds_sdo !== p_sdo) &&
             !(p_clk === 1'b1 && lvds_clk === 1'b0))
            viol_cnt++;
         if (p_clk === 1'b0 && lvds_clk === 1'b1) begin
            if (have_rise && (cyc - last_rise) != PERIOD) bad_period++;
            have_rise = 1'b1;
            last_rise = cyc;
            if (lvds_frame === 1'b1) begin
               if (rx_bitcnt == 0 && gap_pending) begin
                  rx_gaps.push_back(low_cnt);
                  gap_pending = 1'b0;
               end
               rx_shreg = {rx_shreg[30:0], lvds_sdo};
               rx_bitcnt++;
            end else begin
               if (rx_bitcnt != 0) begin
                  rx_words.push_back(rx_shreg);
                  rx_bits.push_back(rx_bitcnt);
                  rx_bitcnt   = 0;
                  low_cnt     = 0;
                  gap_pending = 1'b1;
               end
               low_cnt++;
               if (low_cnt > 8) gap_pending = 1'b0;   // idle between packets
            end
         end
         if (tx_if.o_tx_done === 1'b1) begin
            if (p_done === 1'b1) done_long++;
            else                 done_cnt++;
         end
      end
      p_clk   = lvds_clk;
      p_frame = lvds_frame;
      p_sdo   = lvds_sdo;
      p_done  = tx_if.o_tx_done;
      p_rst   = rst_n;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_data(input pkt_t p);
      tx_if.i_start = p[0];
      tx_if.i_sto11 = p[1];
      tx_if.i_sto12 = p[2];
      tx_if.i_sto21 = p[3];
      tx_if.i_sto22 = p[4];
   endtask

   task automatic set_junk();
      pkt_t j = '{32'hA5A5_0001, 32'h5A5A_0002, 32'hC3C3_0003, 32'h3C3C_0004, 32'h0F0F_0005};
      set_data(j);
   endtask

   // Waits (bounded) for ready, presents one accept cycle, then scrambles data.
   task automatic send(input pkt_t p, input string tag);
      int n = 0;
      while (tx_if.o_tx_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (tx_if.o_tx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s ready_wait: o_tx_ready=%b after %0d cycles, want 1", tag, tx_if.o_tx_ready, n);
      end
      set_data(p);
      tx_if.i_tx_valid = 1'b1;
      @(negedge clk);
      tx_if.i_tx_valid = 1'b0;
      set_junk();
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (tx_if.o_tx_done !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (tx_if.o_tx_done !== 1'b1) begin
         miscompares++;
         $display("FAIL %s done_timeout: o_tx_done=%b after %0d cycles, want 1", tag, tx_if.o_tx_done, n);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      string      nm [6] = '{"lvds_clk", "lvds_frame", "lvds_sdo", "tx_ready", "tx_busy", "tx_done"};
      logic [5:0] exp    = 6'b000100;
      logic [5:0] obs;
      rst_n = 1'b0;
      tx_if.i_tx_valid = 1'b0;
      set_junk();
      tick(3);
      obs = {lvds_clk, lvds_frame, lvds_sdo, tx_if.o_tx_ready, tx_if.o_tx_busy, tx_if.o_tx_done};
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (obs[5-i] !== exp[5-i]) begin
            miscompares++;
            $display("FAIL reset_%s: got %b, want %b", nm[i], obs[5-i], exp[5-i]);
         end
      end
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_packet();
      pkt_t p  = '{32'h0001_0010, 32'h0001_0100, GPX2_NO_HIT, GPX2_NO_HIT, GPX2_NO_HIT};
      int   bw = rx_words.size();
      int   bg = rx_gaps.size();
      int   v0 = viol_cnt, bp0 = bad_period, d0 = done_cnt, dl0 = done_long;
      int   n  = 0;
      logic [31:0] got;
      send(p, "pkt");
      vectors++;
      if (tx_if.o_tx_busy !== 1'b1 || tx_if.o_tx_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL pkt_accept: busy=%b ready=%b, want busy=1 ready=0", tx_if.o_tx_busy, tx_if.o_tx_ready);
      end
      while (lvds_frame !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (lvds_frame !== 1'b1 || n > 2 * CLK_DIV + 1) begin
         miscompares++;
         $display("FAIL pkt_latency: frame rose after %0d cycles (frame=%b), want <= %0d", n, lvds_frame, 2 * CLK_DIV + 1);
      end
      wait_done("pkt");
      tick(PERIOD + 4);
      for (int i = 0; i < 5; i++) begin
         got = (bw + i < rx_words.size()) ? rx_words[bw + i] : 'x;
         vectors++;
         if (got !== p[i]) begin
            miscompares++;
            $display("FAIL pkt_word%0d: got %h, want %h", i, got, p[i]);
         end
      end
      for (int i = 0; i < 5; i++) begin
         n = (bw + i < rx_bits.size()) ? rx_bits[bw + i] : -1;
         vectors++;
         if (n != 32) begin
            miscompares++;
            $display("FAIL pkt_bits%0d: got %0d rising edges in frame, want 32", i, n);
         end
      end
      for (int i = 0; i < 4; i++) begin
         n = (bg + i < rx_gaps.size()) ? rx_gaps[bg + i] : -1;
         vectors++;
         if (n != 2) begin
            miscompares++;
            $display("FAIL pkt_gap%0d: got %0d periods, want 2", i, n);
         end
      end
      vectors++;
      if (viol_cnt - v0 != 0) begin
         miscompares++;
         $display("FAIL pkt_edge_timing: got %0d off-edge changes, want 0", viol_cnt - v0);
      end
      vectors++;
      if (bad_period - bp0 != 0) begin
         miscompares++;
         $display("FAIL pkt_period: got %0d bad lvds periods, want 0", bad_period - bp0);
      end
      vectors++;
      if (done_cnt - d0 != 1 || done_long - dl0 != 0) begin
         miscompares++;
         $display("FAIL pkt_done_pulse: got %0d pulses (%0d long), want 1 (0 long)", done_cnt - d0, done_long - dl0);
      end
      vectors++;
      if (tx_if.o_tx_ready !== 1'b1 || tx_if.o_tx_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL pkt_idle: ready=%b busy=%b, want ready=1 busy=0", tx_if.o_tx_ready, tx_if.o_tx_busy);
      end
   endtask

   task automatic test_ignore_busy();
      pkt_t p  = '{32'h0003_1234, 32'h0004_0001, 32'h0005_ABCD, 32'h00FF_FFFF, GPX2_NO_HIT};
      pkt_t x  = '{32'h0011_1111, 32'h0022_2222, 32'h0033_3333, 32'h0044_4444, 32'h0055_5555};
      int   bw = rx_words.size();
      logic [31:0] got;
      send(p, "busy");
      tick(300);
      set_data(x);
      tx_if.i_tx_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if (tx_if.o_tx_ready !== 1'b0 || tx_if.o_tx_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_midpkt: ready=%b busy=%b, want ready=0 busy=1", tx_if.o_tx_ready, tx_if.o_tx_busy);
      end
      tx_if.i_tx_valid = 1'b0;
      set_junk();
      wait_done("busy");
      tick(PERIOD + 4);
      for (int i = 0; i < 5; i++) begin
         got = (bw + i < rx_words.size()) ? rx_words[bw + i] : 'x;
         vectors++;
         if (got !== p[i]) begin
            miscompares++;
            $display("FAIL busy_word%0d: got %h, want %h", i, got, p[i]);
         end
      end
      tick(40);
      vectors++;
      if (rx_words.size() - bw != 5 || rx_bitcnt != 0 || tx_if.o_tx_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_no_queue: words=%0d partial_bits=%0d busy=%b, want 5 0 0",
                  rx_words.size() - bw, rx_bitcnt, tx_if.o_tx_busy);
      end
   endtask

   task automatic test_back_to_back();
      pkt_t a  = '{32'h0010_0001, 32'h0011_0002, 32'h0012_0003, 32'h0013_0004, 32'h0014_0005};
      pkt_t b  = '{32'h0020_8001, GPX2_NO_HIT, 32'h0022_8003, GPX2_NO_HIT, 32'h0024_8005};
      int   bw = rx_words.size();
      int   d0 = done_cnt;
      logic [31:0] got, want;
      set_data(a);
      tx_if.i_tx_valid = 1'b1;
      @(negedge clk);
      wait_done("b2b_a");
      set_data(b);
      @(negedge clk);
      vectors++;
      if (tx_if.o_tx_ready !== 1'b1 || tx_if.o_tx_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_idle_cycle: ready=%b busy=%b, want ready=1 busy=0", tx_if.o_tx_ready, tx_if.o_tx_busy);
      end
      @(negedge clk);
      tx_if.i_tx_valid = 1'b0;
      vectors++;
      if (tx_if.o_tx_busy !== 1'b1 || tx_if.o_tx_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_accept_b: busy=%b ready=%b, want busy=1 ready=0", tx_if.o_tx_busy, tx_if.o_tx_ready);
      end
      set_junk();
      wait_done("b2b_b");
      tick(PERIOD + 4);
      for (int i = 0; i < 10; i++) begin
         got  = (bw + i < rx_words.size()) ? rx_words[bw + i] : 'x;
         want = (i < 5) ? a[i] : b[i - 5];
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL b2b_word%0d: got %h, want %h", i, got, want);
         end
      end
      vectors++;
      if (done_cnt - d0 != 2) begin
         miscompares++;
         $display("FAIL b2b_done_count: got %0d, want 2", done_cnt - d0);
      end
   endtask

   task automatic test_reset_midpacket();
      pkt_t c  = '{32'h0031_0101, 32'h0032_0202, 32'h0033_0303, 32'h0034_0404, 32'h0035_0505};
      pkt_t d  = '{32'h0041_F00D, 32'h0042_BEEF, 32'h0043_CAFE, GPX2_NO_HIT, 32'h0045_0001};
      string      nm [6] = '{"lvds_clk", "lvds_frame", "lvds_sdo", "tx_ready", "tx_busy", "tx_done"};
      logic [5:0] exp    = 6'b000100;
      logic [5:0] obs;
      int   bw = rx_words.size();
      int   n  = 0;
      logic [31:0] got;
      send(c, "rstmid");
      while (!(rx_words.size() - bw >= 3 && rx_bitcnt >= 22) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (rx_words.size() - bw != 3 || rx_bitcnt != 22) begin
         miscompares++;
         $display("FAIL rstmid_position: words=%0d bits=%0d, want 3 22", rx_words.size() - bw, rx_bitcnt);
      end
      rst_n = 1'b0;
      #1;
      obs = {lvds_clk, lvds_frame, lvds_sdo, tx_if.o_tx_ready, tx_if.o_tx_busy, tx_if.o_tx_done};
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (obs[5-i] !== exp[5-i]) begin
            miscompares++;
            $display("FAIL rstmid_%s: got %b, want %b", nm[i], obs[5-i], exp[5-i]);
         end
      end
      tick(3);
      rst_n = 1'b1;
      tick(2);
      vectors++;
      if (tx_if.o_tx_ready !== 1'b1 || rx_words.size() - bw != 3) begin
         miscompares++;
         $display("FAIL rstmid_release: ready=%b words=%0d, want 1 3", tx_if.o_tx_ready, rx_words.size() - bw);
      end
      bw = rx_words.size();
      send(d, "rstmid_d");
      wait_done("rstmid_d");
      tick(PERIOD + 4);
      for (int i = 0; i < 5; i++) begin
         got = (bw + i < rx_words.size()) ? rx_words[bw + i] : 'x;
         vectors++;
         if (got !== d[i]) begin
            miscompares++;
            $display("FAIL rstmid_word%0d: got %h, want %h", i, got, d[i]);
         end
      end
   endtask

   task automatic test_loopback_rise();
      pkt_t p  = '{32'h0001_0000, GPX2_NO_HIT, GPX2_NO_HIT, 32'h0002_0064, GPX2_NO_HIT};
      int   bw = rx_words.size();
      int   rise;
      logic [31:0] w [5];
      for (int i = 0; i < 5; i++) w[i] = '0;
      send(p, "loop");
      wait_done("loop");
      tick(PERIOD + 4);
      for (int i = 0; i < 5; i++)
         if (bw + i < rx_words.size()) w[i] = rx_words[bw + i];
      rise = (int'(w[3][23:16]) - int'(w[0][23:16])) * 40000 + int'(w[3][15:0]) - int'(w[0][15:0]);
      vectors++;
      if (rise != 40100) begin
         miscompares++;
         $display("FAIL loop_rise: got %0d ps, want 40100", rise);
      end
      for (int i = 1; i < 5; i++) begin
         if (i != 3) begin
            vectors++;
            if (w[i] !== 32'hFFFF_FFFF) begin
               miscompares++;
               $display("FAIL loop_nohit%0d: got %h, want ffffffff", i, w[i]);
            end
         end
      end
   endtask

   initial begin
      tx_if.i_tx_valid = 1'b0;
      set_junk();
      test_reset();
      test_packet();
      test_ignore_busy();
      test_back_to_back();
      test_reset_midpacket();
      test_loopback_rise();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
